// File: rtl/sys_onchip_memory_dp.sv
// Dual-port on-chip RAM with byte enables, a configurable read pipeline and an
// optional zero-fill sweep after reset. Port s1 wins byte collisions with s2.
module sys_onchip_memory_dp #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 13,
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clken,
    input  logic [ADDR_WIDTH-1:0]     s1_address,
    input  logic                      s1_chipselect,
    input  logic                      s1_read,
    input  logic                      s1_write,
    input  logic [DATA_WIDTH/8-1:0]   s1_byteenable,
    input  logic [DATA_WIDTH-1:0]     s1_writedata,
    output logic [DATA_WIDTH-1:0]     s1_readdata,
    output logic                      s1_readdatavalid,
    output logic                      s1_waitrequest,
    input  logic [ADDR_WIDTH-1:0]     s2_address,
    input  logic                      s2_chipselect,
    input  logic                      s2_read,
    input  logic                      s2_write,
    input  logic [DATA_WIDTH/8-1:0]   s2_byteenable,
    input  logic [DATA_WIDTH-1:0]     s2_writedata,
    output logic [DATA_WIDTH-1:0]     s2_readdata,
    output logic                      s2_readdatavalid,
    output logic                      s2_waitrequest,
    output logic                      init_done
);

    localparam int unsigned NB    = DATA_WIDTH / 8;
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam state_t                RST_STATE  = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
    localparam logic [ADDR_WIDTH-1:0] SWEEP_LAST = '1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                          state_q;
    state_t                          state_d;
    logic [ADDR_WIDTH-1:0]           sweep_q;
    logic                            clear_c;
    logic                            wait_c;
    logic [1:0]                      rd_acc;
    logic [1:0]                      wr_acc;
    logic [1:0][ADDR_WIDTH-1:0]      p_addr;
    logic [1:0]                      rd_vld;
    logic [1:0][DATA_WIDTH-1:0]      rd_dat;

    // State register and sweep address
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RST_STATE;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            if (clear_c && clken) begin
                sweep_q <= sweep_q + ADDR_WIDTH'(1);
            end
        end
    end

    // Next state: leave CLEAR once the last address has been zeroed
    always_comb begin
        state_d = state_q;
        clear_c = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clear_c = ~reset;
                if (clken && (sweep_q == SWEEP_LAST)) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: state_d = ST_READY;
        endcase
    end

    assign wait_c         = (state_q != ST_READY) | ~clken | reset;
    assign s1_waitrequest = wait_c;
    assign s2_waitrequest = wait_c;
    assign init_done      = (state_q == ST_READY) & ~reset;

    // A write on a port masks a simultaneous read on that same port
    assign wr_acc = {s2_chipselect & s2_write, s1_chipselect & s1_write} & {2{~wait_c}};
    assign rd_acc = {s2_chipselect & s2_read & ~s2_write,
                     s1_chipselect & s1_read & ~s1_write} & {2{~wait_c}};
    assign p_addr = {s2_address, s1_address};

    // Array update: s1 lanes are applied last so they win same-address collisions
    always_ff @(posedge clk) begin
        if (clken) begin
            if (clear_c) begin
                mem[sweep_q] <= '0;
            end
            for (int b = 0; b < NB; b++) begin
                if (wr_acc[1] && s2_byteenable[b]) begin
                    mem[s2_address][b*8 +: 8] <= s2_writedata[b*8 +: 8];
                end
                if (wr_acc[0] && s1_byteenable[b]) begin
                    mem[s1_address][b*8 +: 8] <= s1_writedata[b*8 +: 8];
                end
            end
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic                  vld_a;
        logic [DATA_WIDTH-1:0] dat_a;

        // First read stage samples the array before same-edge writes land
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                vld_a <= 1'b0;
                dat_a <= '0;
            end else if (clken) begin
                vld_a <= rd_acc[p];
                if (rd_acc[p]) begin
                    dat_a <= mem[p_addr[p]];
                end
            end
        end

        if (READ_LATENCY == 2) begin : g_lat2
            logic                  vld_b;
            logic [DATA_WIDTH-1:0] dat_b;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    vld_b <= 1'b0;
                    dat_b <= '0;
                end else if (clken) begin
                    vld_b <= vld_a;
                    if (vld_a) begin
                        dat_b <= dat_a;
                    end
                end
            end

            assign rd_vld[p] = vld_b;
            assign rd_dat[p] = dat_b;
        end else begin : g_lat1
            assign rd_vld[p] = vld_a;
            assign rd_dat[p] = dat_a;
        end
    end

    assign s1_readdata      = rd_dat[0];
    assign s1_readdatavalid = rd_vld[0];
    assign s2_readdata      = rd_dat[1];
    assign s2_readdatavalid = rd_vld[1];

endmodule

// File: tb/tb_sys_onchip_memory_dp.sv
// Bench for sys_onchip_memory_dp: latency-1 and latency-2 instances share
// stimulus; a scoreboard queue holds expected read returns per stream.
module tb_sys_onchip_memory_dp;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 4;

    logic          clk, reset, clken;
    logic [AW-1:0] s1_address, s2_address;
    logic          s1_chipselect, s1_read, s1_write;
    logic          s2_chipselect, s2_read, s2_write;
    logic [3:0]    s1_byteenable, s2_byteenable;
    logic [DW-1:0] s1_writedata, s2_writedata;

    logic [DW-1:0] l1_s1_rd, l1_s2_rd, l2_s1_rd, l2_s2_rd;
    logic          l1_s1_rdv, l1_s2_rdv, l2_s1_rdv, l2_s2_rdv;
    logic          l1_s1_wait, l1_s2_wait, l2_s1_wait, l2_s2_wait;
    logic          l1_init_done, l2_init_done;

    sys_onchip_memory_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) u_l1 (
        .clk(clk), .reset(reset), .clken(clken),
        .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
        .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
        .s1_readdata(l1_s1_rd), .s1_readdatavalid(l1_s1_rdv), .s1_waitrequest(l1_s1_wait),
        .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
        .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
        .s2_readdata(l1_s2_rd), .s2_readdatavalid(l1_s2_rdv), .s2_waitrequest(l1_s2_wait),
        .init_done(l1_init_done)
    );

    sys_onchip_memory_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) u_l2 (
        .clk(clk), .reset(reset), .clken(clken),
        .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
        .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
        .s1_readdata(l2_s1_rd), .s1_readdatavalid(l2_s1_rdv), .s1_waitrequest(l2_s1_wait),
        .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
        .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
        .s2_readdata(l2_s2_rd), .s2_readdatavalid(l2_s2_rdv), .s2_waitrequest(l2_s2_wait),
        .init_done(l2_init_done)
    );

    // Streams: 0 = L1/s1, 1 = L1/s2, 2 = L2/s1, 3 = L2/s2
    typedef struct {
        int          strm;
        int          due;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [16];
    int          en_cnt = 0;
    int          checks = 0;
    int          errors = 0;
    int          last_due [4];
    logic [31:0] last_dat [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (clken) en_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Return monitor: pops each stream in order and checks timing, data and hold
    always @(negedge clk) begin
        logic        v;
        logic [31:0] d;
        int          idx;
        if (!reset) begin
            for (int s = 0; s < 4; s++) begin
                case (s)
                    0:       begin v = l1_s1_rdv; d = l1_s1_rd; end
                    1:       begin v = l1_s2_rdv; d = l1_s2_rd; end
                    2:       begin v = l2_s1_rdv; d = l2_s1_rd; end
                    default: begin v = l2_s2_rdv; d = l2_s2_rd; end
                endcase
                idx = -1;
                for (int i = 0; i < sb.size(); i++) begin
                    if (sb[i].strm == s) begin
                        idx = i;
                        break;
                    end
                end
                if (v) begin
                    if (idx >= 0 && sb[idx].due == en_cnt) begin
                        chk($sformatf("rdata_strm%0d", s), d, sb[idx].data);
                        last_due[s] = en_cnt;
                        last_dat[s] = sb[idx].data;
                        sb.delete(idx);
                    end else if (last_due[s] == en_cnt) begin
                        chk($sformatf("rdv_held_data_strm%0d", s), d, last_dat[s]);
                    end else begin
                        chk($sformatf("unexpected_rdv_strm%0d", s), 32'(v), 32'd0);
                    end
                end else begin
                    if (idx >= 0 && sb[idx].due <= en_cnt) begin
                        chk($sformatf("missing_rdv_strm%0d", s), 32'(v), 32'd1);
                        sb.delete(idx);
                    end
                    chk($sformatf("rdata_hold_strm%0d", s), d, last_dat[s]);
                end
            end
        end
    end

    task automatic set_idle();
        s1_chipselect = 0; s1_read = 0; s1_write = 0; s1_byteenable = 0; s1_address = 0; s1_writedata = 0;
        s2_chipselect = 0; s2_read = 0; s2_write = 0; s2_byteenable = 0; s2_address = 0; s2_writedata = 0;
    endtask

    // One cycle of stimulus; the model and scoreboard see only accepted transfers
    task automatic drive(input logic ce,
                         input logic cs1, input logic r1, input logic w1, input logic [3:0] be1,
                         input logic [3:0] a1, input logic [31:0] d1,
                         input logic cs2, input logic r2, input logic w2, input logic [3:0] be2,
                         input logic [3:0] a2, input logic [31:0] d2);
        exp_t e;
        clken = ce;
        s1_chipselect = cs1; s1_read = r1; s1_write = w1; s1_byteenable = be1; s1_address = a1; s1_writedata = d1;
        s2_chipselect = cs2; s2_read = r2; s2_write = w2; s2_byteenable = be2; s2_address = a2; s2_writedata = d2;
        #1;
        chk("waitrequest", 32'({l1_s1_wait, l1_s2_wait, l2_s1_wait, l2_s2_wait}), ce ? 32'h0 : 32'hF);
        if (ce) begin
            if (cs1 && r1 && !w1) begin
                e.data = model[a1];
                e.strm = 0; e.due = en_cnt + 1; sb.push_back(e);
                e.strm = 2; e.due = en_cnt + 2; sb.push_back(e);
            end
            if (cs2 && r2 && !w2) begin
                e.data = model[a2];
                e.strm = 1; e.due = en_cnt + 1; sb.push_back(e);
                e.strm = 3; e.due = en_cnt + 2; sb.push_back(e);
            end
            for (int b = 0; b < 4; b++) begin
                if (cs2 && w2 && be2[b]) model[a2][b*8 +: 8] = d2[b*8 +: 8];
            end
            for (int b = 0; b < 4; b++) begin
                if (cs1 && w1 && be1[b]) model[a1][b*8 +: 8] = d1[b*8 +: 8];
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b1, 0, 0, 0, 4'h0, 4'h0, 32'h0, 0, 0, 0, 4'h0, 4'h0, 32'h0);
    endtask

    task automatic rd1(input logic [3:0] a);
        drive(1'b1, 1, 1, 0, 4'h0, a, 32'h0, 0, 0, 0, 4'h0, 4'h0, 32'h0);
    endtask

    task automatic rd2(input logic [3:0] a);
        drive(1'b1, 0, 0, 0, 4'h0, 4'h0, 32'h0, 1, 1, 0, 4'h0, a, 32'h0);
    endtask

    task automatic wr1(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        drive(1'b1, 1, 0, 1, be, a, d, 0, 0, 0, 4'h0, 4'h0, 32'h0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        clken = 1'b1;
        set_idle();
        sb.delete();
        for (int s = 0; s < 4; s++) begin
            last_due[s] = -1;
            last_dat[s] = 32'h0;
        end
        repeat (2) @(negedge clk);
        #1;
        chk("rst_flags", 32'({l1_init_done, l2_init_done, l1_s1_wait, l1_s2_wait, l2_s1_wait, l2_s2_wait,
                              l1_s1_rdv, l1_s2_rdv, l2_s1_rdv, l2_s2_rdv}), 32'h0F0);
        chk("rst_rdata_l1s1", l1_s1_rd, 32'h0);
        chk("rst_rdata_l1s2", l1_s2_rd, 32'h0);
        chk("rst_rdata_l2s1", l2_s1_rd, 32'h0);
        chk("rst_rdata_l2s2", l2_s2_rd, 32'h0);
    endtask

    task automatic release_and_wait();
        int n;
        reset = 1'b0;
        n = 0;
        while (!l1_init_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("init_done_cycles", 32'(n), 32'd16);
        chk("init_done_l2", 32'(l2_init_done), 32'd1);
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        clken = 1'b1;
        set_idle();
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        apply_reset();
        release_and_wait();

        // Every address reads zero after the sweep
        for (int a = 0; a < 16; a++) begin
            drive(1'b1, 1, 1, 0, 4'h0, 4'(a), 32'h0, 1, 1, 0, 4'h0, 4'(15 - a), 32'h0);
        end
        idle(3);

        // Write then back-to-back reads
        wr1(4'd5, 32'hDEADBEEF, 4'hF);
        rd1(4'd5);
        rd1(4'd5);
        rd1(4'd6);
        idle(3);

        // Same-edge byte-lane collision
        drive(1'b1, 1, 0, 1, 4'b1100, 4'd3, 32'h11223344, 1, 0, 1, 4'b0110, 4'd3, 32'hAABBCCDD);
        rd1(4'd3);
        idle(3);

        // Read-during-write on the other port returns old data
        wr1(4'd7, 32'h9, 4'hF);
        drive(1'b1, 1, 0, 1, 4'hF, 4'd7, 32'h5, 1, 1, 0, 4'h0, 4'd7, 32'h0);
        rd2(4'd7);
        idle(3);

        // Zero byteenable write, and read+write on one port acting as write only
        wr1(4'd5, 32'h0, 4'h0);
        drive(1'b1, 0, 0, 0, 4'h0, 4'h0, 32'h0, 1, 1, 1, 4'hF, 4'd9, 32'h12345678);
        rd1(4'd5);
        rd2(4'd9);
        idle(3);

        // clken low holds a returning read; a write attempted meanwhile is ignored
        rd1(4'd3);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 0, 0, 0, 4'h0, 4'h0, 32'h0, 1, 0, 1, 4'hF, 4'd3, 32'hFFFFFFFF);
            #1;
            chk("rdv_held_clken_low", 32'(l1_s1_rdv), 32'd1);
        end
        idle(3);
        rd1(4'd3);
        idle(3);

        // Constrained random traffic on a small address window
        for (int k = 0; k < 300; k++) begin
            logic ce;
            ce = ($urandom_range(0, 9) != 0);
            drive(ce,
                  ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                  4'($urandom), 4'($urandom_range(0, 3)), $urandom,
                  ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                  4'($urandom), 4'($urandom_range(0, 3)), $urandom);
        end
        idle(4);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        // Reset with a read in flight, then reset again mid-sweep
        rd2(4'd3);
        apply_reset();
        reset = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        chk("init_low_mid_sweep", 32'(l1_init_done), 32'd0);
        apply_reset();
        release_and_wait();
        for (int a = 0; a < 16; a++) rd1(4'(a));
        idle(4);
        chk("scoreboard_drained_end", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
